// File: rtl/bsg_manycore_host_link_adapter.sv
// rtl/bsg_manycore_host_link_adapter.sv - host request/response adapter for the manycore loader link
// Credit-limited request issue, host fence, and a small response FIFO for returned load data.
module bsg_manycore_host_link_adapter #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 3,
  parameter int src_x_p           = 0,
  parameter int src_y_p           = 0,
  parameter int max_out_credits_p = 16,
  parameter int load_id_width_p   = 5,
  parameter int rsp_fifo_els_p    = 4
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,

  input  logic                                       host_req_v_i,
  output logic                                       host_req_ready_o,
  input  logic [1:0]                                 host_req_op_i,
  input  logic [addr_width_p-1:0]                    host_req_addr_i,
  input  logic [data_width_p-1:0]                    host_req_data_i,
  input  logic [data_width_p/8-1:0]                  host_req_mask_i,
  input  logic [x_cord_width_p-1:0]                  host_req_x_i,
  input  logic [y_cord_width_p-1:0]                  host_req_y_i,

  output logic                                       out_v_o,
  input  logic                                       out_ready_i,
  output logic                                       out_op_o,
  output logic [addr_width_p-1:0]                    out_addr_o,
  output logic [data_width_p-1:0]                    out_data_o,
  output logic [data_width_p/8-1:0]                  out_mask_o,
  output logic [x_cord_width_p-1:0]                  out_x_o,
  output logic [y_cord_width_p-1:0]                  out_y_o,
  output logic [x_cord_width_p-1:0]                  out_src_x_o,
  output logic [y_cord_width_p-1:0]                  out_src_y_o,
  output logic [load_id_width_p-1:0]                 out_load_id_o,

  input  logic                                       returned_v_i,
  input  logic                                       returned_type_i,
  input  logic [data_width_p-1:0]                    returned_data_i,
  input  logic [load_id_width_p-1:0]                 returned_load_id_i,
  output logic                                       returned_yumi_o,

  output logic                                       host_rsp_v_o,
  output logic [data_width_p-1:0]                    host_rsp_data_o,
  output logic [load_id_width_p-1:0]                 host_rsp_load_id_o,
  input  logic                                       host_rsp_yumi_i,

  output logic [$clog2(max_out_credits_p+1)-1:0]     out_credits_o,
  output logic                                       error_o
);

  localparam int mask_width_lp  = data_width_p / 8;
  localparam int cred_width_lp  = $clog2(max_out_credits_p + 1);
  localparam int ptr_width_lp   = (rsp_fifo_els_p > 1) ? $clog2(rsp_fifo_els_p) : 1;
  localparam int cnt_width_lp   = $clog2(rsp_fifo_els_p + 1);
  localparam int entry_width_lp = data_width_p + load_id_width_p;

  localparam logic [cred_width_lp-1:0] max_credits_lp = cred_width_lp'(max_out_credits_p);
  localparam logic [cnt_width_lp-1:0]  fifo_els_lp    = cnt_width_lp'(rsp_fifo_els_p);
  localparam logic [ptr_width_lp-1:0]  last_ptr_lp    = ptr_width_lp'(rsp_fifo_els_p - 1);

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_send  = 2'd1,
    e_fence = 2'd2
  } state_e;

  state_e state_r, state_n;

  logic                        accept_req;
  logic                        send_fire;

  logic                        op_r;
  logic [addr_width_p-1:0]     addr_r;
  logic [data_width_p-1:0]     data_r;
  logic [mask_width_lp-1:0]    mask_r;
  logic [x_cord_width_p-1:0]   x_r;
  logic [y_cord_width_p-1:0]   y_r;
  logic [load_id_width_p-1:0]  pkt_load_id_r;

  logic [cred_width_lp-1:0]    credits_r;
  logic [load_id_width_p-1:0]  load_id_r;
  logic                        error_r;

  logic [entry_width_lp-1:0]   fifo_mem [rsp_fifo_els_p];
  logic [ptr_width_lp-1:0]     wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0]     count_r;
  logic                        fifo_full;
  logic                        enq, deq;
  logic [entry_width_lp-1:0]   head;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n          = state_r;
    host_req_ready_o = (state_r == e_idle) && (credits_r != '0);
    accept_req       = host_req_ready_o & host_req_v_i;
    send_fire        = 1'b0;
    case (state_r)
      e_idle: begin
        if (accept_req) begin
          case (host_req_op_i)
            2'd0, 2'd1: state_n = e_send;
            2'd2:       state_n = e_fence;
            default:    state_n = e_idle;
          endcase
        end
      end
      e_send: begin
        if (out_ready_i) begin
          send_fire = 1'b1;
          state_n   = e_idle;
        end
      end
      e_fence: begin
        if (credits_r == max_credits_lp) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // Packet fields are captured once at accept and held until the network takes them.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_r          <= 1'b0;
      addr_r        <= '0;
      data_r        <= '0;
      mask_r        <= '0;
      x_r           <= '0;
      y_r           <= '0;
      pkt_load_id_r <= '0;
    end else if (accept_req && !host_req_op_i[1]) begin
      op_r          <= host_req_op_i[0];
      addr_r        <= host_req_addr_i;
      data_r        <= host_req_data_i;
      mask_r        <= host_req_mask_i;
      x_r           <= host_req_x_i;
      y_r           <= host_req_y_i;
      pkt_load_id_r <= host_req_op_i[0] ? '0 : load_id_r;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_r <= max_credits_lp;
      load_id_r <= '0;
      error_r   <= 1'b0;
    end else begin
      if (accept_req && (host_req_op_i == 2'd3)) error_r <= 1'b1;
      if (send_fire && !op_r) load_id_r <= load_id_r + 1'b1;
      // A return arriving with every credit already home is a protocol violation.
      case ({send_fire, returned_yumi_o})
        2'b10: credits_r <= credits_r - 1'b1;
        2'b01: begin
          if (credits_r == max_credits_lp) error_r <= 1'b1;
          else                             credits_r <= credits_r + 1'b1;
        end
        default: credits_r <= credits_r;
      endcase
    end
  end

  assign fifo_full       = (count_r == fifo_els_lp);
  assign returned_yumi_o = returned_v_i & (returned_type_i | ~fifo_full);
  assign enq             = returned_yumi_o & ~returned_type_i;
  assign deq             = host_rsp_yumi_i & (count_r != '0);

  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem[wr_ptr_r] <= {returned_data_i, returned_load_id_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head               = fifo_mem[rd_ptr_r];
  assign host_rsp_v_o       = (count_r != '0);
  assign host_rsp_data_o    = head[entry_width_lp-1 -: data_width_p];
  assign host_rsp_load_id_o = head[load_id_width_p-1:0];

  assign out_v_o       = (state_r == e_send);
  assign out_op_o      = op_r;
  assign out_addr_o    = addr_r;
  assign out_data_o    = data_r;
  assign out_mask_o    = mask_r;
  assign out_x_o       = x_r;
  assign out_y_o       = y_r;
  assign out_src_x_o   = x_cord_width_p'(src_x_p);
  assign out_src_y_o   = y_cord_width_p'(src_y_p);
  assign out_load_id_o = pkt_load_id_r;
  assign out_credits_o = credits_r;
  assign error_o       = error_r;

endmodule

// File: tb/tb_bsg_manycore_host_link_adapter.sv
// tb/tb_bsg_manycore_host_link_adapter.sv - directed self-checking bench for the host link adapter
module tb_bsg_manycore_host_link_adapter;

  logic        clk;
  logic        rst_n;
  logic        host_req_v;
  logic        host_req_ready;
  logic [1:0]  host_req_op;
  logic [27:0] host_req_addr;
  logic [31:0] host_req_data;
  logic [3:0]  host_req_mask;
  logic [3:0]  host_req_x;
  logic [2:0]  host_req_y;
  logic        out_v;
  logic        out_ready;
  logic        out_op;
  logic [27:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic [3:0]  out_x;
  logic [2:0]  out_y;
  logic [3:0]  out_src_x;
  logic [2:0]  out_src_y;
  logic [4:0]  out_load_id;
  logic        returned_v;
  logic        returned_type;
  logic [31:0] returned_data;
  logic [4:0]  returned_load_id;
  logic        returned_yumi;
  logic        host_rsp_v;
  logic [31:0] host_rsp_data;
  logic [4:0]  host_rsp_load_id;
  logic        host_rsp_yumi;
  logic [4:0]  out_credits;
  logic        error;

  int checks = 0;
  int errors = 0;

  bsg_manycore_host_link_adapter dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .host_req_v_i       (host_req_v),
    .host_req_ready_o   (host_req_ready),
    .host_req_op_i      (host_req_op),
    .host_req_addr_i    (host_req_addr),
    .host_req_data_i    (host_req_data),
    .host_req_mask_i    (host_req_mask),
    .host_req_x_i       (host_req_x),
    .host_req_y_i       (host_req_y),
    .out_v_o            (out_v),
    .out_ready_i        (out_ready),
    .out_op_o           (out_op),
    .out_addr_o         (out_addr),
    .out_data_o         (out_data),
    .out_mask_o         (out_mask),
    .out_x_o            (out_x),
    .out_y_o            (out_y),
    .out_src_x_o        (out_src_x),
    .out_src_y_o        (out_src_y),
    .out_load_id_o      (out_load_id),
    .returned_v_i       (returned_v),
    .returned_type_i    (returned_type),
    .returned_data_i    (returned_data),
    .returned_load_id_i (returned_load_id),
    .returned_yumi_o    (returned_yumi),
    .host_rsp_v_o       (host_rsp_v),
    .host_rsp_data_o    (host_rsp_data),
    .host_rsp_load_id_o (host_rsp_load_id),
    .host_rsp_yumi_i    (host_rsp_yumi),
    .out_credits_o      (out_credits),
    .error_o            (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accepts one request and lets it leave with out_ready held high.
  task automatic issue(input logic [1:0] op, input logic [27:0] addr);
    host_req_v    = 1'b1;
    host_req_op   = op;
    host_req_addr = addr;
    step();
    host_req_v = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    host_req_v = 1'b0; host_req_op = 2'd0; host_req_addr = '0; host_req_data = '0;
    host_req_mask = '0; host_req_x = '0; host_req_y = '0; out_ready = 1'b1;
    returned_v = 1'b0; returned_type = 1'b0; returned_data = '0; returned_load_id = '0;
    host_rsp_yumi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_v", out_v, 0);
    chk("rst_credits", out_credits, 16);
    chk("rst_rsp_v", host_rsp_v, 0);
    chk("rst_ret_yumi", returned_yumi, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", host_req_ready, 1);
    rst_n = 1'b1;
    step();

    // single store
    host_req_v = 1'b1; host_req_op = 2'd1; host_req_addr = 28'h100; host_req_data = 32'hDEADBEEF;
    host_req_mask = 4'hF; host_req_x = 4'd1; host_req_y = 3'd2;
    #1 chk("st_ready", host_req_ready, 1);
    chk("st_out_v_pre", out_v, 0);
    step();
    host_req_v = 1'b0;
    chk("st_out_v", out_v, 1);
    chk("st_op", out_op, 1);
    chk("st_addr", out_addr, 28'h100);
    chk("st_data", out_data, 32'hDEADBEEF);
    chk("st_mask", out_mask, 4'hF);
    chk("st_x", out_x, 1);
    chk("st_y", out_y, 2);
    chk("st_src", {out_src_x, out_src_y}, 0);
    chk("st_load_id", out_load_id, 0);
    chk("st_ready_send", host_req_ready, 0);
    step();
    chk("st_out_v_done", out_v, 0);
    chk("st_credits", out_credits, 15);
    returned_v = 1'b1; returned_type = 1'b1;
    #1 chk("ack_yumi", returned_yumi, 1);
    step();
    returned_v = 1'b0;
    chk("ack_credits", out_credits, 16);
    chk("ack_rsp_v", host_rsp_v, 0);

    // 16 loads, no returns
    host_req_x = 4'd0; host_req_y = 3'd0;
    for (int i = 0; i < 16; i++) begin
      host_req_v = 1'b1; host_req_op = 2'd0; host_req_addr = 28'(i);
      #1 chk("ld_ready", host_req_ready, 1);
      step();
      host_req_v = 1'b0;
      chk("ld_out_v", out_v, 1);
      chk("ld_load_id", out_load_id, i);
      chk("ld_op", out_op, 0);
      step();
    end
    chk("ld_credits0", out_credits, 0);
    host_req_v = 1'b1;
    #1 chk("ld_ready0", host_req_ready, 0);
    step();
    host_req_v = 1'b0;
    chk("ld_blocked", out_v, 0);
    returned_v = 1'b1; returned_type = 1'b0; returned_data = 32'hA0; returned_load_id = 5'd0;
    step();
    returned_v = 1'b0;
    chk("ld_ready_back", host_req_ready, 1);
    chk("ld_credits1", out_credits, 1);
    chk("ld_rsp_v", host_rsp_v, 1);
    chk("ld_rsp_data", host_rsp_data, 32'hA0);
    chk("ld_rsp_id", host_rsp_load_id, 0);
    host_rsp_yumi = 1'b1;
    step();
    host_rsp_yumi = 1'b0;
    chk("ld_rsp_empty", host_rsp_v, 0);
    returned_v = 1'b1; returned_type = 1'b1;
    for (int i = 0; i < 15; i++) step();
    returned_v = 1'b0;
    chk("ld_credits_full", out_credits, 16);

    // stalled network
    out_ready = 1'b0;
    host_req_v = 1'b1; host_req_op = 2'd0; host_req_addr = 28'h2AB; host_req_x = 4'd3; host_req_y = 3'd5;
    step();
    host_req_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_v", out_v, 1);
      chk("stall_addr", out_addr, 28'h2AB);
      chk("stall_xy", {out_x, out_y}, {4'd3, 3'd5});
      chk("stall_id", out_load_id, 16);
      chk("stall_credits", out_credits, 16);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("stall_done", out_v, 0);
    chk("stall_credits_dec", out_credits, 15);
    returned_v = 1'b1; returned_type = 1'b1;
    step();
    returned_v = 1'b0;
    chk("stall_credits_back", out_credits, 16);

    // response FIFO fill with host not dequeuing
    for (int i = 0; i < 5; i++) issue(2'd0, 28'h300);
    chk("fifo_credits_out", out_credits, 11);
    for (int i = 0; i < 4; i++) begin
      returned_v = 1'b1; returned_type = 1'b0; returned_data = 32'h1000 + i; returned_load_id = 5'(i);
      #1 chk("fifo_yumi", returned_yumi, 1);
      step();
    end
    returned_data = 32'h1004; returned_load_id = 5'd4;
    #1 chk("fifo_full_yumi", returned_yumi, 0);
    step();
    chk("fifo_full_yumi2", returned_yumi, 0);
    chk("fifo_head_data", host_rsp_data, 32'h1000);
    chk("fifo_head_id", host_rsp_load_id, 0);
    chk("fifo_credits", out_credits, 15);
    host_rsp_yumi = 1'b1;
    #1 chk("fifo_no_bypass", returned_yumi, 0);
    step();
    host_rsp_yumi = 1'b0;
    #1 chk("fifo_yumi_after_deq", returned_yumi, 1);
    step();
    returned_v = 1'b0;
    chk("fifo_credits_all", out_credits, 16);
    for (int i = 1; i < 5; i++) begin
      chk("fifo_order_v", host_rsp_v, 1);
      chk("fifo_order_data", host_rsp_data, 32'h1000 + i);
      chk("fifo_order_id", host_rsp_load_id, i);
      host_rsp_yumi = 1'b1;
      step();
      host_rsp_yumi = 1'b0;
    end
    chk("fifo_drained", host_rsp_v, 0);
    chk("fifo_error", error, 0);

    // fence with 3 outstanding
    for (int i = 0; i < 3; i++) issue(2'd0, 28'h400);
    chk("fence_credits", out_credits, 13);
    host_req_v = 1'b1; host_req_op = 2'd2;
    step();
    host_req_v = 1'b0;
    chk("fence_ready", host_req_ready, 0);
    chk("fence_no_send", out_v, 0);
    step();
    chk("fence_ready_wait", host_req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      returned_v = 1'b1; returned_type = 1'b1;
      step();
      returned_v = 1'b0;
      chk("fence_ready_ret", host_req_ready, 0);
    end
    chk("fence_credits_full", out_credits, 16);
    step();
    chk("fence_release", host_req_ready, 1);

    // send and return in the same cycle, then spurious return
    issue(2'd1, 28'h500);
    chk("same_pre", out_credits, 15);
    host_req_v = 1'b1; host_req_op = 2'd0;
    step();
    host_req_v = 1'b0;
    chk("same_out_v", out_v, 1);
    returned_v = 1'b1; returned_type = 1'b1;
    step();
    returned_v = 1'b0;
    chk("same_credits", out_credits, 15);
    chk("same_error", error, 0);
    returned_v = 1'b1;
    step();
    chk("spur_pre_credits", out_credits, 16);
    #1 chk("spur_yumi", returned_yumi, 1);
    step();
    returned_v = 1'b0;
    chk("spur_error", error, 1);
    chk("spur_credits", out_credits, 16);

    // reset mid-SEND
    out_ready = 1'b0;
    host_req_v = 1'b1; host_req_op = 2'd1; host_req_addr = 28'h55;
    step();
    host_req_v = 1'b0;
    chk("mid_out_v", out_v, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_out_v", out_v, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_credits", out_credits, 16);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // reserved op
    host_req_v = 1'b1; host_req_op = 2'd3;
    step();
    host_req_v = 1'b0;
    chk("op3_error", error, 1);
    chk("op3_out_v", out_v, 0);
    chk("op3_ready", host_req_ready, 1);
    chk("op3_credits", out_credits, 16);
    host_req_v = 1'b1; host_req_op = 2'd0;
    step();
    host_req_v = 1'b0;
    chk("post_rst_out_v", out_v, 1);
    chk("post_rst_load_id", out_load_id, 0);
    step();
    chk("post_rst_credits", out_credits, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_host_link_adapter.md
Name: bsg_manycore_host_link_adapter

Overview:
- Host-side stage that feeds the manycore loader link (io port 0, north edge, x=0) and consumes the responses that come back on it.
- Converts host request beats into manycore request packets and enforces an endpoint-style credit limit on outstanding requests.
- Pushes returned load data into a response FIFO for the host; store acks only return credits.
- Implements host FENCE: the block stalls until all credits have returned.

Parameters:
- addr_width_p, 28, word address width of manycore packets
- data_width_p, 32, data width; the mask width is data_width_p/8
- x_cord_width_p, 4, destination/source x coordinate width
- y_cord_width_p, 3, destination/source y coordinate width
- src_x_p, 0, constant source x stamped on every packet
- src_y_p, 0, constant source y stamped on every packet
- max_out_credits_p, 16, maximum outstanding requests, >=1
- load_id_width_p, 5, width of the load tag counter
- rsp_fifo_els_p, 4, response FIFO depth, >=2

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- host_req_v_i  in  1  host request valid
- host_req_ready_o  out  1  host request ready (valid/ready handshake)
- host_req_op_i  in  2  0=load, 1=store, 2=fence, 3=reserved
- host_req_addr_i  in  addr_width_p  destination word address
- host_req_data_i  in  data_width_p  store data
- host_req_mask_i  in  data_width_p/8  store byte mask
- host_req_x_i  in  x_cord_width_p  destination x
- host_req_y_i  in  y_cord_width_p  destination y
- out_v_o  out  1  request packet valid
- out_ready_i  in  1  network accepts the packet
- out_op_o  out  1  0=load, 1=store
- out_addr_o, out_data_o, out_mask_o, out_x_o, out_y_o  out  as host_req_*  packet fields
- out_src_x_o  out  x_cord_width_p  equals src_x_p
- out_src_y_o  out  y_cord_width_p  equals src_y_p
- out_load_id_o  out  load_id_width_p  tag for loads; 0 for stores
- returned_v_i  in  1  returned packet valid
- returned_type_i  in  1  0=load data, 1=store ack
- returned_data_i  in  data_width_p  returned load data
- returned_load_id_i  in  load_id_width_p  returned tag
- returned_yumi_o  out  1  returned packet consumed this cycle
- host_rsp_v_o  out  1  response FIFO not empty
- host_rsp_data_o  out  data_width_p  head data
- host_rsp_load_id_o  out  load_id_width_p  head tag
- host_rsp_yumi_i  in  1  host dequeues head; legal only when host_rsp_v_o=1
- out_credits_o  out  clog2(max_out_credits_p+1)  available credits
- error_o  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_v_o=0, credits=max_out_credits_p, load_id=0, response FIFO empty, host_rsp_v_o=0, returned_yumi_o=0, error_o=0. A reset mid-operation drops any pending packet and queued responses.
- States: IDLE, SEND, FENCE.
- host_req_ready_o = (state==IDLE) & (credits!=0).
- IDLE, accept with op 0/1: register the packet fields and go to SEND. out_v_o=1 on the next cycle (1-cycle latency). Fields stay stable while out_v_o=1.
- IDLE, accept with op 2: go to FENCE. Nothing is sent.
- IDLE, accept with op 3: set error_o, stay in IDLE, drop the request.
- SEND: on out_v_o & out_ready_i, decrement credits and return to IDLE. If the op is a load, load_id increments modulo 2^load_id_width_p in the same cycle.
- FENCE: stay until credits==max_out_credits_p, then return to IDLE on the following edge. Pending returns are still consumed during FENCE.
- returned_yumi_o = returned_v_i & (returned_type_i==1 | ~rsp_fifo_full). This is combinational. The FIFO full flag is not bypassed by a same-cycle host dequeue.
- On returned_yumi_o: increment credits. If the type is load, enqueue {data, load_id}.
- A send and a credit return in the same cycle leave credits unchanged.
- A credit return when credits==max: credits saturate at max and error_o is set.
- Response FIFO: FIFO order, depth rsp_fifo_els_p. Enqueue and dequeue in the same cycle are allowed when not full; occupancy is then unchanged.
- Back-to-back requests: at most one request per 2 cycles (IDLE→SEND→IDLE). Throughput is not a goal.

Test Plan:
- Reset, then one store (addr 0x100, data 0xDEADBEEF, mask 0xF, x=1, y=2) with out_ready_i=1 → out_v_o high exactly 1 cycle after accept with matching fields. Credits go 16→15. A store-ack return brings credits back to 16 and host_rsp_v_o stays 0.
- 16 loads with returns withheld → host_req_ready_o drops once credits=0. Load ids 0..15 appear in order. One return re-raises ready on the next cycle.
- out_ready_i held low 5 cycles while out_v_o=1 → packet fields stable, credits unchanged until the accepting cycle.
- 5 load returns arrive while the host never dequeues (depth 4) → 4 enqueued; returned_yumi_o=0 on the 5th until one host_rsp_yumi_i. Data is returned in order.
- Fence issued with 3 loads outstanding → host_req_ready_o stays 0 until the 3rd return, then IDLE on the next cycle.
- Send and return in the same cycle keeps credits at 15. A spurious return at credits=16 sets error_o. Reset_n_i asserted mid-SEND immediately clears out_v_o and error_o.
